// File: rtl/msi_pkg.sv
// Shared types and helpers for the MSI interrupt scheduler: vector allocation,
// source-to-vector aliasing and the data-field mask derived from MME.
package msi_pkg;

    localparam int MSI_MAX_VECTORS = 32;
    localparam int MSI_IDX_W       = 5;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } msi_sched_state_t;

    // Encodings above 5 would exceed the 32-vector architectural limit.
    function automatic logic [2:0] msi_mme_eff(input logic [2:0] mme);
        return (mme > 3'd5) ? 3'd5 : mme;
    endfunction

    function automatic logic [5:0] msi_alloc(input logic [2:0] mme);
        return 6'd1 << msi_mme_eff(mme);
    endfunction

    function automatic logic [4:0] msi_alias(input logic [5:0] src, input logic [5:0] alloc);
        logic [5:0] v;
        v = (src < alloc) ? src : alloc - 6'd1;
        return v[4:0];
    endfunction

    function automatic logic [15:0] msi_data_mask(input logic [2:0] mme);
        return (16'd1 << msi_mme_eff(mme)) - 16'd1;
    endfunction

endpackage

// File: rtl/msi_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping
// through bit 31 back to bit 0. Produces a one-hot grant and its index.
module msi_rr_arbiter
    import msi_pkg::*;
(
    input  logic [MSI_MAX_VECTORS-1:0] req,
    input  logic [MSI_IDX_W-1:0]       ptr,
    output logic [MSI_MAX_VECTORS-1:0] gnt,
    output logic [MSI_IDX_W-1:0]       idx,
    output logic                       any
);

    logic [2*MSI_MAX_VECTORS-1:0] dbl;
    logic [MSI_MAX_VECTORS-1:0]   rot;
    logic [MSI_IDX_W-1:0]         off;

    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[MSI_MAX_VECTORS-1:0];
        off = '0;
        // Scan downward so the lowest set offset is the one left standing.
        for (int j = MSI_MAX_VECTORS - 1; j >= 0; j--) begin
            if (rot[j]) off = MSI_IDX_W'(j);
        end
        any = |req;
        idx = ptr + off;
        gnt = any ? (32'd1 << idx) : '0;
    end

endmodule

// File: rtl/msi_interrupt_scheduler.sv
// Collects interrupt events into pending MSI vectors and issues one MSI write at
// a time with round-robin fairness. Optional per-vector masking: MSI_PER_VECTOR_MASK_EN.
module msi_interrupt_scheduler
    import msi_pkg::*;
#(
    parameter int NUM_SOURCES = 32,
    parameter int RR_INIT     = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   msi_enable,
    input  logic [2:0]             mme,
    input  logic [63:0]            cfg_msg_addr,
    input  logic [15:0]            cfg_msg_data,
`ifdef MSI_PER_VECTOR_MASK_EN
    input  logic [31:0]            mask_bits,
`endif
    input  logic [NUM_SOURCES-1:0] int_req,
    output logic                   msg_valid,
    input  logic                   msg_ready,
    output logic [63:0]            msg_addr,
    output logic                   msg_addr64,
    output logic [15:0]            msg_data,
    output logic [31:0]            pending
);

    msi_sched_state_t state_q, state_d;
    logic [31:0]      pending_q, pending_d;
    logic [4:0]       rr_ptr_q, rr_ptr_d;
    logic [4:0]       sel_q, sel_d;
    logic             msg_valid_q, msg_valid_d;
    logic [63:0]      msg_addr_q, msg_addr_d;
    logic             msg_addr64_q, msg_addr64_d;
    logic [15:0]      msg_data_q, msg_data_d;

    logic [5:0]  alloc;
    logic [15:0] dmask;
    logic [31:0] alloc_mask;
    logic [31:0] set_vec;
    logic [31:0] clr_vec;
    logic [31:0] eligible;
    logic [31:0] arb_gnt;
    logic [4:0]  arb_idx;
    logic        arb_any;
    logic        hs;
    logic [5:0]  nxt_ptr;

    assign alloc = msi_alloc(mme);
    assign dmask = msi_data_mask(mme);
    assign hs    = msg_valid_q && msg_ready;

    always_comb begin
        alloc_mask = '0;
        for (int i = 0; i < MSI_MAX_VECTORS; i++) begin
            alloc_mask[i] = (6'(i) < alloc);
        end
    end

    // Sources beyond the allocation all collapse onto the last vector.
    always_comb begin
        set_vec = '0;
        for (int s = 0; s < NUM_SOURCES; s++) begin
            if (int_req[s] && msi_enable) set_vec[msi_alias(6'(s), alloc)] = 1'b1;
        end
    end

`ifdef MSI_PER_VECTOR_MASK_EN
    assign eligible = pending_q & alloc_mask & ~mask_bits;
`else
    assign eligible = pending_q & alloc_mask;
`endif

    msi_rr_arbiter u_arb (
        .req (eligible),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign nxt_ptr = {1'b0, sel_q} + 6'd1;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        sel_d        = sel_q;
        msg_valid_d  = msg_valid_q;
        msg_addr_d   = msg_addr_q;
        msg_addr64_d = msg_addr64_q;
        msg_data_d   = msg_data_q;
        clr_vec      = '0;
        case (state_q)
            IDLE: begin
                if (msi_enable && arb_any) begin
                    sel_d        = arb_idx;
                    msg_valid_d  = 1'b1;
                    msg_addr_d   = cfg_msg_addr;
                    msg_addr64_d = |cfg_msg_addr[63:32];
                    msg_data_d   = (cfg_msg_data & ~dmask) | ({11'd0, arb_idx} & dmask);
                    state_d      = SEND;
                end
            end
            SEND: begin
                // Payload is frozen here; only the handshake moves us on.
                if (hs) begin
                    clr_vec     = 32'd1 << sel_q;
                    rr_ptr_d    = (nxt_ptr >= alloc) ? 5'd0 : nxt_ptr[4:0];
                    msg_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Clear before set so a fresh event on the sent vector survives.
        pending_d = ((pending_q & ~clr_vec) | set_vec) & alloc_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            rr_ptr_q     <= 5'(RR_INIT);
            sel_q        <= '0;
            msg_valid_q  <= 1'b0;
            msg_addr_q   <= '0;
            msg_addr64_q <= 1'b0;
            msg_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            rr_ptr_q     <= rr_ptr_d;
            sel_q        <= sel_d;
            msg_valid_q  <= msg_valid_d;
            msg_addr_q   <= msg_addr_d;
            msg_addr64_q <= msg_addr64_d;
            msg_data_q   <= msg_data_d;
        end
    end

    assign msg_valid  = msg_valid_q;
    assign msg_addr   = msg_addr_q;
    assign msg_addr64 = msg_addr64_q;
    assign msg_data   = msg_data_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_msi_interrupt_scheduler.sv
// Scoreboard bench for msi_interrupt_scheduler: a transaction-level reference
// model predicts each MSI write; a negedge monitor compares on every handshake.
module tb_msi_interrupt_scheduler;

    typedef struct {
        logic [63:0] addr;
        logic        addr64;
        logic [15:0] data;
    } msg_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        msi_enable = 1'b0;
    logic [2:0]  mme = 3'd0;
    logic [63:0] cfg_msg_addr = '0;
    logic [15:0] cfg_msg_data = '0;
    logic [31:0] mask_bits = '0;
    logic [31:0] int_req = '0;
    logic        msg_valid;
    logic        msg_ready = 1'b0;
    logic [63:0] msg_addr;
    logic        msg_addr64;
    logic [15:0] msg_data;
    logic [31:0] pending;

    int n_tests = 0;
    int n_fail  = 0;

    msg_t exp_q[$];
    msg_t log_q[$];

    bit [31:0] m_pend;
    int        m_rr;
    bit        m_busy;
    int        m_sel;

    always #5 clk = ~clk;

    msi_interrupt_scheduler #(.NUM_SOURCES(32), .RR_INIT(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .msi_enable   (msi_enable),
        .mme          (mme),
        .cfg_msg_addr (cfg_msg_addr),
        .cfg_msg_data (cfg_msg_data),
`ifdef MSI_PER_VECTOR_MASK_EN
        .mask_bits    (mask_bits),
`endif
        .int_req      (int_req),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .msg_addr     (msg_addr),
        .msg_addr64   (msg_addr64),
        .msg_data     (msg_data),
        .pending      (pending)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ralloc(input int m);
        return 1 << ((m > 5) ? 5 : m);
    endfunction

    function automatic int ralias(input int s, input int a);
        return (s < a) ? s : a - 1;
    endfunction

    function automatic bit quiet();
        int a;
        bit any_el;
        a = ralloc(int'(mme));
        any_el = 0;
        for (int i = 0; i < a; i++) if (m_pend[i] && !mask_bits[i]) any_el = 1;
        return !m_busy && (!msi_enable || !any_el);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = '0;
            m_rr   = 0;
            m_busy = 0;
            m_sel  = 0;
            exp_q.delete();
        end else begin
            int a, m, clear, k;
            bit found;
            msg_t e;
            a = ralloc(int'(mme));
            m = (mme > 5) ? 5 : int'(mme);
            clear = -1;
            if (m_busy) begin
                if (msg_ready) begin
                    clear  = m_sel;
                    m_rr   = (m_sel + 1 >= a) ? 0 : m_sel + 1;
                    m_busy = 0;
                end
            end else if (msi_enable) begin
                found = 0;
                for (int j = 0; j < 32; j++) begin
                    k = (m_rr + j) % 32;
                    if (!found && k < a && m_pend[k] && !mask_bits[k]) begin
                        found = 1;
                        m_sel = k;
                    end
                end
                if (found) begin
                    m_busy   = 1;
                    e.addr   = cfg_msg_addr;
                    e.addr64 = (cfg_msg_addr[63:32] != 0);
                    e.data   = 16'(((int'(cfg_msg_data) >> m) << m) + (m_sel % (1 << m)));
                    exp_q.push_back(e);
                end
            end
            if (clear >= 0) m_pend[clear] = 0;
            for (int s = 0; s < 32; s++) if (int_req[s] && msi_enable) m_pend[ralias(s, a)] = 1;
            for (int i = 0; i < 32; i++) if (i >= a) m_pend[i] = 0;
        end
    end

    // ---------------- monitor ----------------
    bit   prev_valid = 0;
    bit   prev_hs = 0;
    msg_t prev_msg;

    always @(negedge clk) begin
        if (!rst) begin
            msg_t got, e;
            chk("valid", 64'(msg_valid), 64'(m_busy));
            chk("pending", 64'(pending), 64'(m_pend));
            got.addr = msg_addr;
            got.addr64 = msg_addr64;
            got.data = msg_data;
            if (prev_valid && !prev_hs) begin
                chk("hold_valid", 64'(msg_valid), 64'd1);
                chk("hold_data", 64'(msg_data), 64'(prev_msg.data));
                chk("hold_addr", msg_addr, prev_msg.addr);
            end
            if (msg_valid && msg_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_msg", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("msg_addr", got.addr, e.addr);
                    chk("msg_addr64", 64'(got.addr64), 64'(e.addr64));
                    chk("msg_data", 64'(got.data), 64'(e.data));
                end
                log_q.push_back(got);
            end
            prev_valid = msg_valid;
            prev_hs    = msg_valid && msg_ready;
            prev_msg   = got;
        end else begin
            prev_valid = 0;
            prev_hs    = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input logic [31:0] v);
        int_req = v;
        tick();
        int_req = '0;
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && !quiet(); i++) tick();
        chk(name, 64'(quiet()), 64'd1);
        tick();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", 64'(msg_valid), 64'd0);
        chk("rst_addr", msg_addr, 64'd0);
        chk("rst_addr64", 64'(msg_addr64), 64'd0);
        chk("rst_data", 64'(msg_data), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);

        // single message, mme=0, plus idle latency
        msi_enable = 1; mme = 0; cfg_msg_data = 16'hABCD;
        cfg_msg_addr = 64'h0000_0000_FEE0_0000; msg_ready = 1;
        log_q.delete();
        pulse(32'h1 << 3);
        tick();
        chk("latency_valid", 64'(msg_valid), 64'd1);
        drain("t1_drain", 50);
        chk("t1_count", 64'(log_q.size()), 64'd1);
        if (log_q.size() > 0) chk("t1_data", 64'(log_q[0].data), 64'hABCD);
        chk("t1_pending", 64'(pending), 64'd0);

        // two vectors in round-robin order, 64-bit address
        mme = 3; cfg_msg_data = 16'h1230; cfg_msg_addr = 64'h0000_0001_FEE0_1000;
        log_q.delete();
        pulse((32'h1 << 2) | (32'h1 << 5));
        drain("t2_drain", 50);
        chk("t2_count", 64'(log_q.size()), 64'd2);
        if (log_q.size() > 1) begin
            chk("t2_data0", 64'(log_q[0].data), 64'h1232);
            chk("t2_data1", 64'(log_q[1].data), 64'h1235);
            chk("t2_addr64", 64'(log_q[0].addr64), 64'd1);
        end

        // aliasing and coalescing with 4 vectors
        mme = 2; cfg_msg_addr = 64'h0000_0000_FEE0_2000;
        log_q.delete();
        pulse(32'h1 << 9);
        drain("t3_drain", 50);
        chk("t3_count", 64'(log_q.size()), 64'd1);
        if (log_q.size() > 0) chk("t3_data", 64'(log_q[0].data), 64'h1233);
        log_q.delete();
        pulse((32'h1 << 3) | (32'h1 << 9));
        drain("t3b_drain", 50);
        chk("t3b_count", 64'(log_q.size()), 64'd1);

        // back-pressure, then re-arm in the handshake cycle
        log_q.delete();
        msg_ready = 0;
        pulse(32'h1 << 1);
        for (int i = 0; i < 10; i++) tick();
        chk("bp_valid", 64'(msg_valid), 64'd1);
        msg_ready = 1;
        pulse(32'h1 << 1);
        drain("t4_drain", 50);
        chk("t4_count", 64'(log_q.size()), 64'd2);
        if (log_q.size() > 1) chk("t4_data1", 64'(log_q[1].data), 64'h1231);

        // disabled requests are dropped; disable during SEND still completes
        log_q.delete();
        msi_enable = 0;
        pulse(32'h1 << 1);
        tick();
        chk("dis_pending", 64'(pending), 64'd0);
        chk("dis_count", 64'(log_q.size()), 64'd0);
        msi_enable = 1; msg_ready = 0;
        pulse(32'h1 << 0);
        tick();
        msi_enable = 0;
        tick(); tick(); tick();
        msg_ready = 1;
        drain("t5_drain", 50);
        chk("t5_count", 64'(log_q.size()), 64'd1);
        msi_enable = 1;

`ifdef MSI_PER_VECTOR_MASK_EN
        mme = 3; log_q.delete();
        mask_bits = 32'h1 << 4;
        pulse(32'h1 << 4);
        tick(); tick(); tick();
        chk("mask_pending", 64'(pending[4]), 64'd1);
        chk("mask_count", 64'(log_q.size()), 64'd0);
        mask_bits = '0;
        tick();
        chk("unmask_valid", 64'(msg_valid), 64'd1);
        drain("t6_drain", 50);
`endif

        // asynchronous reset mid-SEND
        msg_ready = 0; mme = 3;
        pulse(32'h1 << 6);
        tick();
        #1 rst = 1;
        #1;
        chk("arst_valid", 64'(msg_valid), 64'd0);
        chk("arst_pending", 64'(pending), 64'd0);
        tick();
        rst = 0;

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int_req   = ($urandom_range(0, 3) == 0) ? ($urandom() & $urandom() & $urandom()) : '0;
            msg_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 49) == 0) mme = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) begin
                cfg_msg_data = 16'($urandom());
                cfg_msg_addr = ($urandom_range(0, 1) == 0) ? {32'd0, $urandom()} : {$urandom(), $urandom()};
            end
            if ($urandom_range(0, 99) == 0) msi_enable = ~msi_enable;
`ifdef MSI_PER_VECTOR_MASK_EN
            if ($urandom_range(0, 39) == 0) mask_bits = $urandom() & $urandom();
`endif
            tick();
        end
        int_req = '0; msi_enable = 1; msg_ready = 1; mask_bits = '0;
        drain("rand_drain", 500);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
